extend_pipe: RTL and testbench
==============================

EXTEND_PIPE -- requirements
Module: extend_pipe

Interface
REQ-001 Parameter CNT_W, default 16: width of the saturating statistics counters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  upstream word offered.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 in_data  input  32  raw word; only the low field selected by in_size is significant.
REQ-007 in_size  input  2  field size: 00 byte [7:0], 01 half [15:0], 10 word [31:0], 11 reserved.
REQ-008 in_mode  input  2  fill mode: 00 zero-fill, 01 sign-extend, 10 ones-fill, 11 reserved.
REQ-009 out_valid  output  1  extended word available.
REQ-010 out_ready  input  1  downstream accepts the word this cycle.
REQ-011 out_data  output  32  extended word.
REQ-012 out_err  output  1  word came from a reserved in_size or in_mode code; qualified by out_valid.
REQ-013 word_cnt  output  CNT_W  saturating count of words delivered downstream.
REQ-014 err_cnt  output  CNT_W  saturating count of delivered words with out_err=1.

Function
REQ-015 Input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; output transfer on a rising edge with out_valid=1 and out_ready=1.
REQ-016 Extension SHALL be combinational on the input side and the result SHALL be stored in a 2-entry FIFO; the FIFO head drives out_data/out_err.
REQ-017 Byte: result[7:0]=in_data[7:0]; bits [31:8] = 0 (zero), in_data[7] (sign), 1 (ones).
REQ-018 Half: result[15:0]=in_data[15:0]; bits [31:16] filled as in REQ-017 using in_data[15] for sign.
REQ-019 Word: result = in_data unchanged in every valid mode.
REQ-020 Reserved in_size or in_mode: result SHALL be 32'h0000_0000 with err=1; the word is still accepted and delivered in order.
REQ-021 Latency: a word accepted at edge N SHALL appear with out_valid=1 after edge N when the FIFO was empty; no combinational path from in_* to out_*.
REQ-022 in_ready SHALL equal "FIFO not full" and SHALL NOT depend on out_ready.
REQ-023 FIFO states EMPTY (0), ONE (1), FULL (2); accept-only increments, deliver-only decrements, simultaneous accept and deliver holds count.
REQ-024 Simultaneous accept and deliver in FULL is impossible (in_ready=0); in ONE it SHALL keep ordering with the new word behind the head.
REQ-025 out_valid SHALL equal "FIFO not empty"; out_data/out_err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 Words SHALL be delivered in acceptance order with none dropped or duplicated.
REQ-027 word_cnt SHALL increment on every output transfer, err_cnt on every output transfer with out_err=1; both SHALL hold at 2^CNT_W-1.
REQ-028 in_data/in_size/in_mode SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-029 rst=1 SHALL immediately force FIFO to EMPTY: out_valid=0, in_ready=1 (from reset release onward), out_data=0, out_err=0, word_cnt=0, err_cnt=0.
REQ-030 Reset asserted mid-operation SHALL discard all buffered words; no word accepted before reset SHALL appear after it.
REQ-031 First transfer SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-032 Byte modes: in_data=32'h0000_0080, size=00, mode 00/01/10 -> out_data 32'h0000_0080 / 32'hFFFF_FF80 / 32'hFFFF_FF80; in_data=32'h1234_5601 mode 10 -> 32'hFFFF_FF01.
REQ-033 Half/word: in_data=32'hABCD_7FFF size=01 mode=01 -> 32'h0000_7FFF; size=10 mode=10 -> 32'hABCD_7FFF; out_err=0 throughout.
REQ-034 Reserved: size=11 or mode=11 with in_data=32'hFFFF_FFFF -> out_data=0, out_err=1, err_cnt increments by 1 per delivered word.
REQ-035 Backpressure: out_ready=0, send 3 words -> third waits with in_ready=0 after two accepted; raise out_ready -> all three delivered in order, out_data stable while stalled.
REQ-036 Throughput: in_valid=1 and out_ready=1 continuously for 100 words -> one word per cycle after 1-cycle latency, word_cnt=100.
REQ-037 Reset mid-stream: FIFO FULL, pulse rst asynchronously between edges -> out_valid drops immediately, counters read 0, no pre-reset word emerges.

Source files
------------

// File: rtl/extend_pipe_if.sv
// Handshake bundle for extend_pipe: upstream raw words in, extended words and statistics out.
// The master modport is the environment side, the slave modport is the extender.
interface extend_pipe_if #(
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [1:0]       in_size;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_err;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, in_data, in_size, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_err, word_cnt, err_cnt
  );

  modport slave (
    input  in_valid, in_data, in_size, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_err, word_cnt, err_cnt
  );
endinterface

// File: rtl/extend_pipe.sv
// Zero/sign/ones extension of byte, half or word fields into a 2-entry output FIFO,
// with saturating counters of delivered words and delivered error words.
module extend_pipe #(
  parameter int unsigned CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  extend_pipe_if.slave bus
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [31:0]      mem_data_q [2];
  logic [1:0]       mem_err_q;
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic        push;
  logic        pop;
  logic        sign_bit;
  logic        fill_bit;
  logic        ext_err;
  logic [31:0] ext_data;

  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  always_comb begin
    ext_err  = (bus.in_size == 2'b11) || (bus.in_mode == 2'b11);
    sign_bit = (bus.in_size == 2'b00) ? bus.in_data[7] : bus.in_data[15];
    fill_bit = (bus.in_mode == 2'b10) || ((bus.in_mode == 2'b01) && sign_bit);
    ext_data = '0;
    case (bus.in_size)
      2'b00:   ext_data = {{24{fill_bit}}, bus.in_data[7:0]};
      2'b01:   ext_data = {{16{fill_bit}}, bus.in_data[15:0]};
      2'b10:   ext_data = bus.in_data;
      default: ext_data = '0;
    endcase
    if (ext_err) begin
      ext_data = '0;
    end
  end

  // Occupancy FSM; in_ready/out_valid are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (push) begin
            state_q     <= StOne;
            out_valid_q <= 1'b1;
          end
        end
        StOne: begin
          if (push && !pop) begin
            state_q    <= StFull;
            in_ready_q <= 1'b0;
          end else if (!push && pop) begin
            state_q     <= StEmpty;
            out_valid_q <= 1'b0;
          end
        end
        StFull: begin
          if (pop) begin
            state_q    <= StOne;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= StEmpty;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage is cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_data_q[0] <= '0;
      mem_data_q[1] <= '0;
      mem_err_q     <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
    end else begin
      if (push) begin
        mem_data_q[wr_ptr_q] <= ext_data;
        mem_err_q[wr_ptr_q]  <= ext_err;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else if (pop) begin
      if (word_cnt_q != {CNT_W{1'b1}}) begin
        word_cnt_q <= word_cnt_q + CNT_W'(1);
      end
      if (mem_err_q[rd_ptr_q] && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = mem_data_q[rd_ptr_q];
  assign bus.out_err   = mem_err_q[rd_ptr_q];
  assign bus.word_cnt  = word_cnt_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_extend_pipe.sv
// Bench for extend_pipe: fixed vectors, backpressure/throughput/reset sequences and random
// traffic scored against an arithmetic model; a narrow-counter twin checks saturation.
module tb_extend_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  extend_pipe_if #(.CNT_W(16)) dif ();
  extend_pipe_if #(.CNT_W(3))  sif ();

  extend_pipe #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(dif.slave));
  extend_pipe #(.CNT_W(3))  dut_small (.clk(clk), .rst(rst), .bus(sif.slave));

  assign sif.in_valid  = dif.in_valid;
  assign sif.in_data   = dif.in_data;
  assign sif.in_size   = dif.in_size;
  assign sif.in_mode   = dif.in_mode;
  assign sif.out_ready = dif.out_ready;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: keep the low 8<<size bits, then fill above them by mode.
  function automatic logic [32:0] ref_ext(input logic [31:0] d, input logic [1:0] size,
                                          input logic [1:0] mode);
    longint unsigned span, low, ones, res;
    if (size == 2'd3 || mode == 2'd3) return {1'b1, 32'h0};
    span = 64'd1 << (8 << size);
    low  = {32'h0, d} % span;
    ones = low | (64'hFFFF_FFFF & ~(span - 64'd1));
    case (mode)
      2'd0:    res = low;
      2'd1:    res = (low >= span / 2) ? ones : low;
      default: res = ones;
    endcase
    return {1'b0, res[31:0]};
  endfunction

  logic [32:0] exp_q[$];
  int word_m = 0;
  int err_m  = 0;

  // Scoreboard: at mid-cycle, decide which handshakes the next rising edge performs.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      exp_q.delete();
      word_m = 0;
      err_m  = 0;
    end else begin
      if (dif.out_valid && dif.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h expected none", dif.out_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_out_data", dif.out_data, e[31:0]);
          check("sb_out_err", {31'b0, dif.out_err}, {31'b0, e[32]});
          word_m++;
          if (e[32]) err_m++;
        end
      end
      if (dif.in_valid && dif.in_ready)
        exp_q.push_back(ref_ext(dif.in_data, dif.in_size, dif.in_mode));
    end
  end

  typedef struct {
    logic [31:0] d;
    logic [1:0]  size;
    logic [1:0]  mode;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t tbl[13];

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] wa;
    int n;
    int n_err;

    tbl[0]  = '{32'h0000_0080, 2'd0, 2'd0, 32'h0000_0080, 1'b0};
    tbl[1]  = '{32'h0000_0080, 2'd0, 2'd1, 32'hFFFF_FF80, 1'b0};
    tbl[2]  = '{32'h0000_0080, 2'd0, 2'd2, 32'hFFFF_FF80, 1'b0};
    tbl[3]  = '{32'h1234_5601, 2'd0, 2'd2, 32'hFFFF_FF01, 1'b0};
    tbl[4]  = '{32'h1234_5601, 2'd0, 2'd1, 32'h0000_0001, 1'b0};
    tbl[5]  = '{32'hABCD_7FFF, 2'd1, 2'd1, 32'h0000_7FFF, 1'b0};
    tbl[6]  = '{32'hABCD_7FFF, 2'd2, 2'd2, 32'hABCD_7FFF, 1'b0};
    tbl[7]  = '{32'h1234_8001, 2'd1, 2'd1, 32'hFFFF_8001, 1'b0};
    tbl[8]  = '{32'h1234_8001, 2'd1, 2'd0, 32'h0000_8001, 1'b0};
    tbl[9]  = '{32'hFFFF_FFFF, 2'd3, 2'd0, 32'h0000_0000, 1'b1};
    tbl[10] = '{32'hFFFF_FFFF, 2'd0, 2'd3, 32'h0000_0000, 1'b1};
    tbl[11] = '{32'hFFFF_FFFF, 2'd3, 2'd3, 32'h0000_0000, 1'b1};
    tbl[12] = '{32'h8765_4321, 2'd2, 2'd0, 32'h8765_4321, 1'b0};

    dif.in_valid  = 1'b0;
    dif.in_data   = '0;
    dif.in_size   = '0;
    dif.in_mode   = '0;
    dif.out_ready = 1'b0;
    rst           = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, dif.out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, dif.in_ready}, 32'd1);
    check("rst_out_data", dif.out_data, 32'd0);
    check("rst_out_err", {31'b0, dif.out_err}, 32'd0);
    check("rst_word_cnt", {16'b0, dif.word_cnt}, 32'd0);
    check("rst_err_cnt", {16'b0, dif.err_cnt}, 32'd0);

    // Release just after an edge; the first vector is offered for the very next edge.
    @(posedge clk);
    #1 rst = 1'b0;

    n_err = 0;
    for (int i = 0; i < 13; i++) begin
      dif.in_valid = 1'b1;
      dif.in_data  = tbl[i].d;
      dif.in_size  = tbl[i].size;
      dif.in_mode  = tbl[i].mode;
      @(posedge clk);
      #1 dif.in_valid = 1'b0;
      dif.in_data = $urandom;
      check($sformatf("vec%0d_out_valid", i), {31'b0, dif.out_valid}, 32'd1);
      check($sformatf("vec%0d_out_data", i), dif.out_data, tbl[i].exp_d);
      check($sformatf("vec%0d_out_err", i), {31'b0, dif.out_err}, {31'b0, tbl[i].exp_e});
      dif.out_ready = 1'b1;
      @(posedge clk);
      #1 dif.out_ready = 1'b0;
      check($sformatf("vec%0d_drained", i), {31'b0, dif.out_valid}, 32'd0);
      if (tbl[i].exp_e) n_err++;
    end
    check("vec_word_cnt", {16'b0, dif.word_cnt}, 32'd13);
    check("vec_err_cnt", {16'b0, dif.err_cnt}, n_err);

    // Backpressure: two words fill the FIFO, the third must wait.
    dif.in_valid = 1'b1;
    dif.in_size  = 2'd2;
    dif.in_mode  = 2'd0;
    dif.in_data  = 32'hA000_0001;
    wa = ref_ext(32'hA000_0001, 2'd2, 2'd0);
    @(posedge clk);
    #1 dif.in_data = 32'hB000_0002;
    @(posedge clk);
    #1 dif.in_data = 32'hC000_0003;
    check("bp_full_in_ready", {31'b0, dif.in_ready}, 32'd0);
    check("bp_head", dif.out_data, wa[31:0]);
    @(posedge clk);
    #1 check("bp_still_full", {31'b0, dif.in_ready}, 32'd0);
    check("bp_head_stable", dif.out_data, wa[31:0]);
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1 check("bp_reopen", {31'b0, dif.in_ready}, 32'd1);
    @(posedge clk);
    #1 dif.in_valid = 1'b0;
    n = 0;
    while (dif.out_valid && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    check("bp_drained", {31'b0, dif.out_valid}, 32'd0);
    dif.out_ready = 1'b0;
    check("bp_word_cnt", {16'b0, dif.word_cnt}, 32'd16);

    // Random traffic with occupancy tracked by the scoreboard queue.
    for (int c = 0; c < 400; c++) begin
      dif.in_valid  = ($urandom_range(0, 3) != 0);
      dif.in_data   = $urandom;
      dif.in_size   = 2'($urandom_range(0, 3));
      dif.in_mode   = 2'($urandom_range(0, 3));
      dif.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      check("rnd_out_valid", {31'b0, dif.out_valid}, {31'b0, exp_q.size() != 0});
      check("rnd_in_ready", {31'b0, dif.in_ready}, {31'b0, exp_q.size() < 2});
    end
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b1;
    n = 0;
    while (dif.out_valid && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    check("rnd_drained", {31'b0, dif.out_valid}, 32'd0);
    dif.out_ready = 1'b0;
    check("rnd_word_cnt", {16'b0, dif.word_cnt}, word_m);
    check("rnd_err_cnt", {16'b0, dif.err_cnt}, err_m);
    check("sat_word_cnt", {29'b0, sif.word_cnt}, sat(word_m, 7));
    check("sat_err_cnt", {29'b0, sif.err_cnt}, sat(err_m, 7));

    // Reset mid-stream with the FIFO full.
    dif.in_valid = 1'b1;
    dif.in_size  = 2'd2;
    dif.in_mode  = 2'd1;
    dif.in_data  = 32'hDEAD_0001;
    @(posedge clk);
    #1 dif.in_data = 32'hDEAD_0002;
    @(posedge clk);
    #1 dif.in_valid = 1'b0;
    check("mid_full", {31'b0, dif.in_ready}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("mid_out_valid", {31'b0, dif.out_valid}, 32'd0);
    check("mid_word_cnt", {16'b0, dif.word_cnt}, 32'd0);
    check("mid_err_cnt", {16'b0, dif.err_cnt}, 32'd0);
    check("mid_out_data", dif.out_data, 32'd0);
    exp_q.delete();
    word_m = 0;
    err_m  = 0;
    rst = 1'b0;
    check("mid_in_ready", {31'b0, dif.in_ready}, 32'd1);
    dif.in_valid  = 1'b1;
    dif.in_size   = 2'd1;
    dif.in_mode   = 2'd0;
    dif.in_data   = 32'h5555_1234;
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1 dif.in_valid = 1'b0;
    check("post_rst_word", dif.out_data, 32'h0000_1234);
    @(posedge clk);
    #1 check("post_rst_empty", {31'b0, dif.out_valid}, 32'd0);
    check("post_rst_word_cnt", {16'b0, dif.word_cnt}, 32'd1);

    // Throughput: fresh counters, 100 back-to-back words.
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    exp_q.delete();
    word_m = 0;
    err_m  = 0;
    for (int i = 0; i < 100; i++) begin
      dif.in_valid = 1'b1;
      dif.in_data  = $urandom;
      dif.in_size  = 2'($urandom_range(0, 2));
      dif.in_mode  = 2'($urandom_range(0, 2));
      @(posedge clk);
      #1;
      check("tp_in_ready", {31'b0, dif.in_ready}, 32'd1);
      check("tp_out_valid", {31'b0, dif.out_valid}, 32'd1);
    end
    dif.in_valid = 1'b0;
    @(posedge clk);
    #1 dif.out_ready = 1'b0;
    check("tp_empty", {31'b0, dif.out_valid}, 32'd0);
    check("tp_word_cnt", {16'b0, dif.word_cnt}, 32'd100);
    check("tp_err_cnt", {16'b0, dif.err_cnt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
